// File: rtl/unidade_mult_div_if.sv
// rtl/unidade_mult_div_if.sv - issue and write-back bundle of the multiply/divide unit
interface unidade_mult_div_if #(parameter int LARGURA = 32);
   logic               inicio;
   logic [1:0]         op;
   logic [LARGURA-1:0] dado1;
   logic [LARGURA-1:0] dado2;
   logic [4:0]         rd_in;
   logic               ocupado;
   logic               pronto;
   logic [LARGURA-1:0] hi;
   logic [LARGURA-1:0] lo;
   logic               RegWrite;
   logic [4:0]         rd;
   logic [LARGURA-1:0] dado_escrita;

   modport master (
      output inicio, op, dado1, dado2, rd_in,
      input  ocupado, pronto, hi, lo, RegWrite, rd, dado_escrita
   );

   modport slave (
      input  inicio, op, dado1, dado2, rd_in,
      output ocupado, pronto, hi, lo, RegWrite, rd, dado_escrita
   );
endinterface

// File: rtl/unidade_mult_div.sv
// rtl/unidade_mult_div.sv - radix-2 multi-cycle multiply/divide with HI/LO and write-back pulse
module unidade_mult_div #(
   parameter int LARGURA = 32
) (
   input logic               clock,
   input logic               reset,
   unidade_mult_div_if.slave bus
);
   localparam int W = LARGURA;

   typedef enum logic [1:0] {OCIOSO, CALCULA, AJUSTE} estado_t;

   estado_t          estado_q, estado_d;
   logic [1:0]       op_q, op_d;
   logic [4:0]       rd_lat_q, rd_lat_d;
   logic [4:0]       rd_q, rd_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     a_raw_q, a_raw_d;
   logic [W-1:0]     hi_q, hi_d;
   logic [W-1:0]     lo_q, lo_d;
   logic [W-1:0]     rem_q, rem_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [4:0]       cont_q, cont_d;
   logic             fim_q, fim_d;
   logic             sinal_quo_q, sinal_quo_d;
   logic             sinal_rem_q, sinal_rem_d;
   logic             div_zero_q, div_zero_d;
   logic             ocupado_q, ocupado_d;
   logic             pronto_q, pronto_d;
   logic             regwrite_q, regwrite_d;

   logic             sinal_a, sinal_b;
   logic [W-1:0]     mag_a, mag_b;
   logic [W:0]       soma;
   logic [W:0]       rem_desl;
   logic             cabe;
   logic [W-1:0]     sub;
   logic [2*W-1:0]   prod_final;
   logic [W-1:0]     quo_final, rem_final;

   // Signed operands are reduced to magnitudes; 32'h80000000 maps onto itself, which is the correct unsigned magnitude.
   assign sinal_a = bus.op[0] & bus.dado1[W-1];
   assign sinal_b = bus.op[0] & bus.dado2[W-1];
   assign mag_a   = sinal_a ? -bus.dado1 : bus.dado1;
   assign mag_b   = sinal_b ? -bus.dado2 : bus.dado2;

   assign soma     = {1'b0, acc_q[2*W-1:W]} + {1'b0, a_q};
   assign rem_desl = {rem_q, acc_q[W-1]};
   assign cabe     = rem_desl >= {1'b0, b_q};
   // When the divisor fits, the true difference is below 2^W, so the low word is exact.
   assign sub      = rem_desl[W-1:0] - b_q;

   assign prod_final = sinal_quo_q ? -acc_q : acc_q;
   assign quo_final  = sinal_quo_q ? -acc_q[W-1:0] : acc_q[W-1:0];
   assign rem_final  = sinal_rem_q ? -rem_q : rem_q;

   always_comb begin
      estado_d    = estado_q;
      op_d        = op_q;
      rd_lat_d    = rd_lat_q;
      rd_d        = rd_q;
      a_d         = a_q;
      b_d         = b_q;
      a_raw_d     = a_raw_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      rem_d       = rem_q;
      acc_d       = acc_q;
      cont_d      = cont_q;
      fim_d       = fim_q;
      sinal_quo_d = sinal_quo_q;
      sinal_rem_d = sinal_rem_q;
      div_zero_d  = div_zero_q;
      ocupado_d   = ocupado_q;
      pronto_d    = 1'b0;
      regwrite_d  = 1'b0;

      case (estado_q)
         OCIOSO: begin
            if (bus.inicio) begin
               estado_d    = CALCULA;
               op_d        = bus.op;
               rd_lat_d    = bus.rd_in;
               a_d         = mag_a;
               b_d         = mag_b;
               a_raw_d     = bus.dado1;
               sinal_quo_d = sinal_a ^ sinal_b;
               sinal_rem_d = sinal_a;
               div_zero_d  = (bus.dado2 == '0);
               rem_d       = '0;
               acc_d       = {{W{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
               cont_d      = '0;
               fim_d       = 1'b0;
               ocupado_d   = 1'b1;
            end
         end

         CALCULA: begin
            if (!fim_q) begin
               if (!op_q[1]) begin
                  acc_d = acc_q[0] ? {soma, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
               end else if (cabe) begin
                  rem_d          = sub;
                  acc_d[W-1:0]   = {acc_q[W-2:0], 1'b1};
               end else begin
                  rem_d          = rem_desl[W-1:0];
                  acc_d[W-1:0]   = {acc_q[W-2:0], 1'b0};
               end
               cont_d = cont_q + 5'd1;
               if (cont_q == 5'd31) begin
                  fim_d = 1'b1;
               end
            end else begin
               estado_d   = AJUSTE;
               ocupado_d  = 1'b0;
               pronto_d   = 1'b1;
               regwrite_d = (rd_lat_q != 5'd0);
               rd_d       = rd_lat_q;
               if (!op_q[1]) begin
                  hi_d = prod_final[2*W-1:W];
                  lo_d = prod_final[W-1:0];
               end else if (div_zero_q) begin
                  hi_d = a_raw_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_final;
                  lo_d = quo_final;
               end
            end
         end

         AJUSTE: begin
            estado_d = OCIOSO;
         end

         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q    <= OCIOSO;
         op_q        <= '0;
         rd_lat_q    <= '0;
         rd_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         a_raw_q     <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         rem_q       <= '0;
         acc_q       <= '0;
         cont_q      <= '0;
         fim_q       <= 1'b0;
         sinal_quo_q <= 1'b0;
         sinal_rem_q <= 1'b0;
         div_zero_q  <= 1'b0;
         ocupado_q   <= 1'b0;
         pronto_q    <= 1'b0;
         regwrite_q  <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         op_q        <= op_d;
         rd_lat_q    <= rd_lat_d;
         rd_q        <= rd_d;
         a_q         <= a_d;
         b_q         <= b_d;
         a_raw_q     <= a_raw_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         rem_q       <= rem_d;
         acc_q       <= acc_d;
         cont_q      <= cont_d;
         fim_q       <= fim_d;
         sinal_quo_q <= sinal_quo_d;
         sinal_rem_q <= sinal_rem_d;
         div_zero_q  <= div_zero_d;
         ocupado_q   <= ocupado_d;
         pronto_q    <= pronto_d;
         regwrite_q  <= regwrite_d;
      end
   end

   assign bus.ocupado      = ocupado_q;
   assign bus.pronto       = pronto_q;
   assign bus.hi           = hi_q;
   assign bus.lo           = lo_q;
   assign bus.RegWrite     = regwrite_q;
   assign bus.rd           = rd_q;
   assign bus.dado_escrita = lo_q;
endmodule

// File: tb/tb_unidade_mult_div.sv
// tb/tb_unidade_mult_div.sv - bench for unidade_mult_div against an arithmetic reference model
module tb_unidade_mult_div;
   logic clock;
   logic reset;
   int   total;
   int   passes;
   int   fails;

   unidade_mult_div_if #(.LARGURA(32)) bus ();

   unidade_mult_div #(.LARGURA(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference results straight from integer arithmetic; SV division truncates toward zero.
   function automatic void modelo(input logic [1:0] op_i, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
      logic [63:0] pu;
      longint      x, y, r;
      x = longint'($signed(a));
      y = longint'($signed(b));
      case (op_i)
         2'b00: begin
            pu = {32'd0, a} * {32'd0, b};
            h  = pu[63:32];
            l  = pu[31:0];
         end
         2'b01: begin
            r = x * y;
            h = r[63:32];
            l = r[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               h = a;
               l = 32'hFFFFFFFF;
            end else if (op_i == 2'b10) begin
               h = a % b;
               l = a / b;
            end else begin
               r = x % y;
               h = r[31:0];
               r = x / y;
               l = r[31:0];
            end
         end
      endcase
   endfunction

   task automatic executa(input string nome, input logic [1:0] op_i, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd_i,
                          input bit perturba, input bit segura);
      logic [31:0] e_hi, e_lo;
      int n, wr;
      modelo(op_i, a, b, e_hi, e_lo);
      bus.op     = op_i;
      bus.dado1  = a;
      bus.dado2  = b;
      bus.rd_in  = rd_i;
      bus.inicio = 1'b1;
      @(posedge clock); #1;
      bus.inicio = 1'b0;
      chk({nome, " ocupado"}, 64'(bus.ocupado), 64'd1);
      n  = 0;
      wr = 0;
      while (!bus.pronto && n < 40) begin
         if (perturba && n == 10) begin
            bus.inicio = 1'b1;
            bus.op     = 2'b10;
            bus.dado1  = $urandom;
            bus.dado2  = $urandom;
            bus.rd_in  = 5'd9;
         end else if (perturba && n == 11) begin
            bus.inicio = 1'b0;
         end
         @(posedge clock); #1;
         n++;
         if (bus.RegWrite) wr++;
      end
      chk({nome, " latency"}, 64'(n), 64'd33);
      chk({nome, " hi"}, 64'(bus.hi), 64'(e_hi));
      chk({nome, " lo"}, 64'(bus.lo), 64'(e_lo));
      chk({nome, " dado_escrita"}, 64'(bus.dado_escrita), 64'(e_lo));
      chk({nome, " rd"}, 64'(bus.rd), 64'(rd_i));
      chk({nome, " ocupado_fim"}, 64'(bus.ocupado), 64'd0);
      if (segura) bus.inicio = 1'b1;
      @(posedge clock); #1;
      bus.inicio = 1'b0;
      if (bus.RegWrite) wr++;
      chk({nome, " pronto_pulso"}, 64'(bus.pronto), 64'd0);
      chk({nome, " ocupado_apos"}, 64'(bus.ocupado), 64'd0);
      chk({nome, " regwrite_pulsos"}, 64'(wr), (rd_i != 5'd0) ? 64'd1 : 64'd0);
      chk({nome, " hi_mantido"}, 64'(bus.hi), 64'(e_hi));
   endtask

   initial begin
      logic [1:0]  op_r;
      logic [31:0] a_r, b_r;
      int          wr;
      total  = 0;
      passes = 0;
      fails  = 0;
      reset      = 1'b1;
      bus.inicio = 1'b0;
      bus.op     = 2'b00;
      bus.dado1  = '0;
      bus.dado2  = '0;
      bus.rd_in  = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset ocupado", 64'(bus.ocupado), 64'd0);
      chk("reset pronto", 64'(bus.pronto), 64'd0);
      chk("reset RegWrite", 64'(bus.RegWrite), 64'd0);
      chk("reset rd", 64'(bus.rd), 64'd0);
      chk("reset dado_escrita", 64'(bus.dado_escrita), 64'd0);
      chk("reset hi", 64'(bus.hi), 64'd0);
      chk("reset lo", 64'(bus.lo), 64'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      executa("multu_7x6", 2'b00, 32'd7, 32'd6, 5'd4, 0, 0);
      executa("mult_m2x3", 2'b01, 32'hFFFFFFFE, 32'd3, 5'd5, 0, 0);
      executa("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 0, 0);
      executa("div_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 5'd7, 0, 0);
      executa("divu_100_7", 2'b10, 32'd100, 32'd7, 5'd8, 0, 0);
      executa("divu_15_0", 2'b10, 32'd15, 32'd0, 5'd10, 0, 0);
      executa("div_m5_0", 2'b11, 32'hFFFFFFFB, 32'd0, 5'd11, 0, 0);
      executa("div_overflow", 2'b11, 32'h80000000, 32'hFFFFFFFF, 5'd12, 0, 1);
      executa("restart_ign", 2'b00, 32'd3, 32'd5, 5'd13, 1, 0);
      executa("rd_zero", 2'b01, 32'hFFFFFF00, 32'h00000123, 5'd0, 0, 0);

      for (int i = 0; i < 16; i++) begin
         op_r = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       a_r = $urandom_range(0, 1000);
            1:       a_r = 32'h80000000;
            default: a_r = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0:       b_r = 32'd0;
            1:       b_r = $urandom_range(1, 50);
            2:       b_r = 32'hFFFFFFFF;
            default: b_r = $urandom;
         endcase
         executa($sformatf("rand%0d_op%0d", i, op_r), op_r, a_r, b_r, 5'($urandom_range(0, 31)), 0, 0);
      end

      bus.op     = 2'b10;
      bus.dado1  = 32'd1000;
      bus.dado2  = 32'd3;
      bus.rd_in  = 5'd14;
      bus.inicio = 1'b1;
      @(posedge clock); #1;
      bus.inicio = 1'b0;
      repeat (19) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      chk("midreset ocupado", 64'(bus.ocupado), 64'd0);
      chk("midreset hi", 64'(bus.hi), 64'd0);
      chk("midreset lo", 64'(bus.lo), 64'd0);
      chk("midreset rd", 64'(bus.rd), 64'd0);
      wr = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (bus.RegWrite || bus.pronto) wr++;
      end
      chk("midreset no_writeback", 64'(wr), 64'd0);
      executa("after_reset", 2'b10, 32'd1000, 32'd3, 5'd15, 0, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
